// File: rtl/sr_layer_scheduler_pkg.sv
// Shared types and defaults for the super-resolution layer scheduler.
// Per-layer weight counts derive from each conv's channel shape (3x3 kernels plus bias).
package sr_layer_scheduler_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 6;
  localparam int unsigned ADDR_W_DEF     = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_ERR
  } state_t;

  function automatic int unsigned layer_words(int unsigned n_in, int unsigned n_out);
    return n_in * n_out * 9 + n_out;
  endfunction

  // upsample(3->12), conv1(3->9), conv2..4(9->9), conv5(9->3)
  localparam int unsigned LAYER_WCOUNT [NUM_LAYERS_DEF] = '{
    layer_words(3, 12),
    layer_words(3, 9),
    layer_words(9, 9),
    layer_words(9, 9),
    layer_words(9, 9),
    layer_words(9, 3)
  };

endpackage

// File: rtl/sr_layer_scheduler_watchdog.sv
// Cycle counter for a layer's compute pass; expire flags the last allowed RUN cycle.
module sr_layer_scheduler_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sr_layer_scheduler.sv
// Sequences weight loading and compute launch for each layer of the SR CNN pipeline.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | streaming WCOUNT[layer_idx] weight words, one per cycle
//   SETTLE | loader read latency; layer_go issued on exit
//   RUN    | waiting for layer_done under watchdog
//   ERR    | watchdog expired; err held until start or reset
module sr_layer_scheduler
  import sr_layer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned WCOUNT [NUM_LAYERS] = LAYER_WCOUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              layer_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        layer_idx,
  output logic              load_weights,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              layer_go
);

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_wcount_chk
    if (WCOUNT[i] == 0 || 64'(WCOUNT[i]) >= (64'd1 << ADDR_W)) begin : g_bad
      $error("sr_layer_scheduler: WCOUNT[%0d]=%0d is zero or exceeds address space", i, WCOUNT[i]);
    end
  end

  state_t            state_q, state_d;
  logic [2:0]        idx_d;
  logic [ADDR_W-1:0] addr_d, last_addr;
  logic              load_d, go_d, busy_d, done_d, err_d;
  logic              wd_clear, wd_en, wd_expire;

  assign last_addr = ADDR_W'(WCOUNT[layer_idx] - 1);

  sr_layer_scheduler_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = layer_idx;
    addr_d   = weight_addr;
    load_d   = load_weights;
    busy_d   = busy;
    err_d    = err;
    go_d     = 1'b0;
    done_d   = 1'b0;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      addr_d   = '0;
      load_d   = 1'b0;
      busy_d   = 1'b0;
      wd_clear = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_d = S_LOAD;
            idx_d   = '0;
            addr_d  = '0;
            load_d  = 1'b1;
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (weight_addr == last_addr) begin
            state_d = S_SETTLE;
            load_d  = 1'b0;
            addr_d  = '0;
          end else begin
            addr_d = weight_addr + ADDR_W'(1);
          end
        end
        S_SETTLE: begin
          state_d  = S_RUN;
          go_d     = 1'b1;
          wd_clear = 1'b1;
        end
        S_RUN: begin
          wd_en = 1'b1;
          // layer_done wins over a watchdog expiry in the same cycle
          if (layer_done) begin
            if (layer_idx == 3'(NUM_LAYERS - 1)) begin
              state_d = S_IDLE;
              idx_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_LOAD;
              idx_d   = layer_idx + 3'd1;
              addr_d  = '0;
              load_d  = 1'b1;
            end
          end else if (wd_expire) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      layer_idx    <= '0;
      weight_addr  <= '0;
      load_weights <= 1'b0;
      layer_go     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_idx    <= idx_d;
      weight_addr  <= addr_d;
      load_weights <= load_d;
      layer_go     <= go_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule
